// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O controller:
// CPU memory command encoding and the I/O word-address map.
package mmio_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] ADDR_LED     = 9'h100;
  localparam logic [8:0] ADDR_KEYFLAG = 9'h120;
  localparam logic [8:0] ADDR_SW      = 9'h140;
  localparam logic [8:0] ADDR_CNT_LO  = 9'h180;
  localparam logic [8:0] ADDR_CNT_HI  = 9'h181;

endpackage

// File: rtl/mmio_io_ctrl_sync.sv
// Two-flop synchroniser with a one-cycle falling-edge pulse
// on the synchronised value; reset level is a parameter.
module sync_fall_edge #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= {W{RST_VAL}};
      r_s2   <= {W{RST_VAL}};
      r_prev <= {W{RST_VAL}};
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_fall = r_prev & ~r_s2;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller: LEDs, halt indicator, switches, key flags.
// Cycle counter (CNT_LO/CNT_HI) built only with MMIO_CYCLE_COUNTER_EN.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SW_W  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      mem_cmd,
  input  logic [8:0]      mem_addr,
  input  logic [15:0]     write_data,
  input  logic            halt,
  input  logic [SW_W-1:0] sw,
  input  logic [1:0]      key_n,
  output logic [15:0]     read_data,
  output logic            io_hit,
  output logic [7:0]      ledr,
  output logic            led_halt
);

  if (CNT_W < 17 || CNT_W > 32) begin : g_cnt_w_chk
    $error("CNT_W must be 17..32");
  end

  logic [15:0]     r_rdata;
  logic            r_hit;
  logic [7:0]      r_ledr;
  logic            r_halt;
  logic [1:0]      r_flag;
  logic [15:0]     w_rdata;
  logic [SW_W-1:0] w_sw_sync;
  logic [SW_W-1:0] w_unused_sw_fall;
  logic [1:0]      w_key_fall;
  logic [1:0]      w_unused_key_sync;
  logic            w_unused_wdata;
  logic            w_rd;
  logic            w_wr;
  logic            w_hit_led;
  logic            w_hit_kf;
  logic            w_hit_sw;
  logic            w_io;

  assign w_unused_wdata = ^write_data[15:8];

  sync_fall_edge #(
    .W       (SW_W),
    .RST_VAL (1'b0)
  ) u_sw_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (sw),
    .o_sync  (w_sw_sync),
    .o_fall  (w_unused_sw_fall)
  );

  for (genvar i = 0; i < 2; i++) begin : g_key
    sync_fall_edge #(
      .W       (1),
      .RST_VAL (1'b1)
    ) u_key_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (key_n[i]),
      .o_sync  (w_unused_key_sync[i]),
      .o_fall  (w_key_fall[i])
    );
  end

  assign w_rd      = (mem_cmd == MREAD);
  assign w_wr      = (mem_cmd == MWRITE);
  assign w_hit_led = (mem_addr == ADDR_LED);
  assign w_hit_kf  = (mem_addr == ADDR_KEYFLAG);
  assign w_hit_sw  = (mem_addr == ADDR_SW);

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_shadow;
  logic             w_hit_lo;
  logic             w_hit_hi;

  assign w_hit_lo = (mem_addr == ADDR_CNT_LO);
  assign w_hit_hi = (mem_addr == ADDR_CNT_HI);
  assign w_io = w_hit_led | w_hit_kf | w_hit_sw |
                w_hit_lo | w_hit_hi;

  // Upper bits are frozen into the shadow on a LO read
  // so a following HI read pairs with it coherently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      if (!halt) r_cnt <= r_cnt + CNT_W'(1);
      if (w_rd && w_hit_lo) r_shadow <= 16'(r_cnt >> 16);
    end
  end
`else
  assign w_io = w_hit_led | w_hit_kf | w_hit_sw;
`endif

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_hit_led: w_rdata = {8'h00, r_ledr};
      w_hit_kf:  w_rdata = {14'b0, r_flag};
      w_hit_sw:  w_rdata = 16'(w_sw_sync);
`ifdef MMIO_CYCLE_COUNTER_EN
      w_hit_lo:  w_rdata = r_cnt[15:0];
      w_hit_hi:  w_rdata = r_shadow;
`endif
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_hit   <= 1'b0;
      r_ledr  <= '0;
      r_halt  <= 1'b0;
      r_flag  <= '0;
    end else begin
      r_hit   <= w_rd & w_io;
      r_rdata <= (w_rd & w_io) ? w_rdata : '0;
      if (w_wr && w_hit_led) r_ledr <= write_data[7:0];
      r_halt  <= r_halt | halt;
      // A new edge wins over the clearing read.
      r_flag  <= (r_flag & ~{2{w_rd & w_hit_kf}}) | w_key_fall;
    end
  end

  assign read_data = r_rdata;
  assign io_hit    = r_hit;
  assign ledr      = r_ledr;
  assign led_halt  = r_halt;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed table, corner
// sequences and random traffic against a history-based model.
`timescale 1ns/1ps
module tb_mmio_io_ctrl;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mem_cmd = MNONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic        halt = 1'b0;
  logic [7:0]  sw = '0;
  logic [1:0]  key_n = 2'b11;
  logic [15:0] read_data;
  logic        io_hit;
  logic [7:0]  ledr;
  logic        led_halt;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_io_ctrl #(.CNT_W(32), .SW_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .halt       (halt),
    .sw         (sw),
    .key_n      (key_n),
    .read_data  (read_data),
    .io_hit     (io_hit),
    .ledr       (ledr),
    .led_halt   (led_halt)
  );

  always #5 clk = ~clk;

  // Reference model: inputs kept as a short history of sampled values
  logic [7:0]      m_led;
  bit              m_halt;
  logic [1:0]      m_flag;
  longint unsigned m_cnt;
  logic [15:0]     m_shadow;
  logic [7:0]      m_sw_h [2];
  logic [1:0]      m_key_h [3];
  bit              m_hit;
  logic [15:0]     m_rd;

  function automatic bit is_io(input logic [8:0] a);
    if (a == 9'h100 || a == 9'h120 || a == 9'h140) return 1'b1;
`ifdef MMIO_CYCLE_COUNTER_EN
    if (a == 9'h180 || a == 9'h181) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_led = '0; m_halt = 0; m_flag = '0;
    m_cnt = 0; m_shadow = '0; m_hit = 0; m_rd = '0;
    m_sw_h[0] = '0; m_sw_h[1] = '0;
    for (int i = 0; i < 3; i++) m_key_h[i] = 2'b11;
  endtask

  task automatic model_edge();
    logic [1:0] fall;
    fall  = m_key_h[2] & ~m_key_h[1];
    m_hit = (mem_cmd == MREAD) && is_io(mem_addr);
    m_rd  = '0;
    if (m_hit) begin
      case (mem_addr)
        9'h100: m_rd = {8'h00, m_led};
        9'h120: m_rd = {14'b0, m_flag};
        9'h140: m_rd = {8'h00, m_sw_h[1]};
        9'h180: m_rd = m_cnt[15:0];
        9'h181: m_rd = m_shadow;
        default: m_rd = '0;
      endcase
    end
    if (m_hit && mem_addr == 9'h120) m_flag = '0;
    m_flag = m_flag | fall;
    if (mem_cmd == MWRITE && mem_addr == 9'h100)
      m_led = write_data[7:0];
    if (m_hit && mem_addr == 9'h180)
      m_shadow = 16'(m_cnt >> 16);
    if (!halt) m_cnt = (m_cnt + 1) & 64'hFFFF_FFFF;
    if (halt) m_halt = 1;
    m_sw_h[1]  = m_sw_h[0];
    m_sw_h[0]  = sw;
    m_key_h[2] = m_key_h[1];
    m_key_h[1] = m_key_h[0];
    m_key_h[0] = key_n;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input bit check = 1'b1);
    model_edge();
    @(posedge clk);
    #1;
    if (check) begin
      chk("io_hit", io_hit, m_hit);
      chk("read_data", read_data, m_rd);
      chk("ledr", ledr, m_led);
      chk("led_halt", led_halt, m_halt);
    end
  endtask

  task automatic bus(input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] d = 16'h0);
    mem_cmd = c; mem_addr = a; write_data = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_read_data", read_data, 0);
    chk("rst_io_hit", io_hit, 0);
    chk("rst_ledr", ledr, 0);
    chk("rst_led_halt", led_halt, 0);
    bus(MNONE, 9'h000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic        exp_hit;
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t tbl [12];
  logic [8:0] pick [6];

  initial begin
    tbl[0]  = '{MWRITE, 9'h100, 16'h00A5, 0, 16'h0000, 8'hA5};
    tbl[1]  = '{MREAD,  9'h100, 16'h0000, 1, 16'h00A5, 8'hA5};
    tbl[2]  = '{MREAD,  9'h0FF, 16'h0000, 0, 16'h0000, 8'hA5};
    tbl[3]  = '{MWRITE, 9'h140, 16'hFFFF, 0, 16'h0000, 8'hA5};
    tbl[4]  = '{MWRITE, 9'h101, 16'h0011, 0, 16'h0000, 8'hA5};
    tbl[5]  = '{MREAD,  9'h140, 16'h0000, 1, 16'h0000, 8'hA5};
    tbl[6]  = '{MWRITE, 9'h100, 16'h1234, 0, 16'h0000, 8'h34};
    tbl[7]  = '{MREAD,  9'h100, 16'h0000, 1, 16'h0034, 8'h34};
    tbl[8]  = '{MREAD,  9'h120, 16'h0000, 1, 16'h0000, 8'h34};
    tbl[9]  = '{MNONE,  9'h100, 16'h0000, 0, 16'h0000, 8'h34};
    tbl[10] = '{MREAD,  9'h17F, 16'h0000, 0, 16'h0000, 8'h34};
    tbl[11] = '{MWRITE, 9'h120, 16'h0003, 0, 16'h0000, 8'h34};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus(tbl[i].cmd, tbl[i].addr, tbl[i].wd);
      tick();
      chk($sformatf("tbl%0d_hit", i), io_hit, tbl[i].exp_hit);
      chk($sformatf("tbl%0d_rd", i), read_data, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_led", i), ledr, tbl[i].exp_led);
    end

    // Async reset while a read response is showing
    bus(MREAD, 9'h100);
    tick();
    chk("pre_rst_hit", io_hit, 1);
    do_reset();

    // Switch synchronisation
    sw = 8'h3C;
    bus(MNONE, 9'h000);
    repeat (3) tick();
    bus(MREAD, 9'h140);
    tick();
    chk("sw_read", read_data, 16'h003C);
    chk("sw_hit", io_hit, 1);
    bus(MREAD, 9'h0FF);
    tick();
    chk("non_io_hit", io_hit, 0);
    chk("non_io_rd", read_data, 0);

    // Key press, then clear-on-read
    bus(MNONE, 9'h000);
    key_n = 2'b10;
    repeat (4) tick();
    key_n = 2'b11;
    repeat (3) tick();
    bus(MREAD, 9'h120);
    tick();
    chk("key_flag", read_data, 16'h0001);
    tick();
    chk("key_cleared", read_data, 16'h0000);

    // Edge detected on the same edge as the clearing read
    bus(MNONE, 9'h000);
    key_n = 2'b10;
    repeat (2) tick();
    bus(MREAD, 9'h120);
    tick();
    chk("key_same_edge_rd", read_data, 16'h0000);
    key_n = 2'b11;
    tick();
    chk("key_set_wins", read_data, 16'h0001);

    // Halt is sticky
    bus(MNONE, 9'h000);
    halt = 1'b1;
    tick();
    chk("halt_set", led_halt, 1);
    halt = 1'b0;
    repeat (3) tick();
    chk("halt_sticky", led_halt, 1);
    do_reset();
    chk("halt_after_rst", led_halt, 0);

`ifdef MMIO_CYCLE_COUNTER_EN
    // Counter from reset release, and halt freeze
    repeat (99) tick();
    bus(MREAD, 9'h180);
    tick();
    chk("cnt_lo_100", read_data, 16'd100);
    bus(MREAD, 9'h181);
    tick();
    chk("cnt_hi_0", read_data, 16'd0);
    halt = 1'b1;
    bus(MREAD, 9'h180);
    tick();
    tick();
    chk("cnt_frozen", read_data, 16'd102);
    halt = 1'b0;

    // LO/HI coherence across the 16-bit boundary
    do_reset();
    bus(MNONE, 9'h000);
    repeat (65534) tick(1'b0);
    bus(MREAD, 9'h180);
    tick();
    chk("cnt_lo_ffff", read_data, 16'hFFFF);
    bus(MREAD, 9'h181);
    tick();
    chk("cnt_hi_0_wrap", read_data, 16'h0000);
    bus(MREAD, 9'h180);
    tick();
    chk("cnt_lo_1", read_data, 16'h0001);
    bus(MREAD, 9'h181);
    tick();
    chk("cnt_hi_1", read_data, 16'h0001);
`else
    bus(MREAD, 9'h180);
    tick();
    chk("nocnt_lo_hit", io_hit, 0);
    chk("nocnt_lo_rd", read_data, 0);
    bus(MREAD, 9'h181);
    tick();
    chk("nocnt_hi_hit", io_hit, 0);
    bus(MREAD, 9'h100);
    tick();
    chk("nocnt_led_hit", io_hit, 1);
`endif

    // Random traffic against the model
    do_reset();
    pick[0] = 9'h100; pick[1] = 9'h120; pick[2] = 9'h140;
    pick[3] = 9'h180; pick[4] = 9'h181; pick[5] = 9'h000;
    for (int i = 0; i < 500; i++) begin
      int k;
      k = $urandom_range(0, 5);
      bus(2'($urandom_range(0, 2)),
          (k == 5) ? 9'($urandom) : pick[k],
          16'($urandom));
      sw = 8'($urandom);
      if ($urandom_range(0, 3) == 0) key_n = 2'($urandom);
      halt = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
